// File: rtl/sum_acc4_pkg.sv
// sum_acc_pkg: shared FSM state type and default widths for the adder/accumulator pair
package sum_acc_pkg;
  typedef enum logic [1:0] {IDLE, ACC, DONE} state_t;
  localparam int DEF_DATA_W = 4;
  localparam int DEF_ACC_W = 8;
  localparam int DEF_COUNT = 4;
endpackage

// File: rtl/sum_acc4_sample_counter.sv
// sample_counter: up-counter with clear/enable; tc flags the enabled final count
module sample_counter #(
  parameter int COUNT = 4,
  parameter int W = $clog2(COUNT + 1)
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  input  logic en,
  output logic tc
);
  logic [W-1:0] cnt;
  always_comb tc = en && (cnt == W'(COUNT - 1));
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) cnt <= '0;
    else if (clr) cnt <= '0;
    else if (en) cnt <= cnt + W'(1);
endmodule

// File: rtl/sum_acc4.sv
// sum_acc4: accumulates COUNT adder samples per block and hands the total downstream
module sum_acc4
  import sum_acc_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int ACC_W = DEF_ACC_W,
  parameter int COUNT = DEF_COUNT
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] in_data,
  output logic              in_ready,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [ACC_W-1:0]  acc_out,
  output logic              ovf,
  output logic              busy
);
  state_t state, next;
  logic [ACC_W-1:0] acc;
  logic [ACC_W:0] sum;
  logic accept, clr, tc;
  always_comb begin
    in_ready = state == ACC;
    out_valid = state == DONE;
    busy = state != IDLE;
    acc_out = acc;
    accept = in_valid && in_ready;
    clr = state == IDLE && start;
    sum = {1'b0, acc} + (ACC_W + 1)'(in_data);
    next = state == IDLE ? (start ? ACC : IDLE) :
           state == ACC  ? (tc ? DONE : ACC) :
                           (out_ready ? IDLE : DONE);
  end
  sample_counter #(.COUNT(COUNT)) u_cnt (
    .clk(clk),
    .rst_n(rst_n),
    .clr(clr),
    .en(accept),
    .tc(tc)
  );
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state <= IDLE;
      acc <= '0;
      ovf <= 1'b0;
    end else begin
      state <= next;
      if (clr) begin
        acc <= '0;
        ovf <= 1'b0;
      end else if (accept) begin
        acc <= sum[ACC_W-1:0];
        if (sum[ACC_W]) ovf <= 1'b1;
      end
    end
endmodule

// File: tb/tb_sum_acc4.sv
// tb_sum_acc4: directed table-driven checks of sum_acc4 (COUNT=4) plus a COUNT=20 overflow run
module tb_sum_acc4;
  typedef struct {
    logic st, iv;
    logic [3:0] d;
    logic ordy;
    logic e_ir, e_ov;
    logic [7:0] e_acc;
    logic e_ovf, e_busy;
  } vec_t;

  logic clk = 0, rst_n = 0;
  logic start = 0, in_valid = 0, out_ready = 0;
  logic [3:0] in_data = 0;
  logic in_ready, out_valid, ovf, busy;
  logic [7:0] acc_out;
  logic s20 = 0, v20 = 0, or20 = 0;
  logic [3:0] d20 = 0;
  logic ir20, ov20, ovf20, busy20;
  logic [7:0] acc20;
  int checks = 0, errors = 0;
  vec_t tbl[$];

  always #5 clk = ~clk;

  sum_acc4 #(.DATA_W(4), .ACC_W(8), .COUNT(4)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .in_valid(in_valid), .in_data(in_data),
    .in_ready(in_ready), .out_valid(out_valid), .out_ready(out_ready),
    .acc_out(acc_out), .ovf(ovf), .busy(busy)
  );

  sum_acc4 #(.DATA_W(4), .ACC_W(8), .COUNT(20)) dut20 (
    .clk(clk), .rst_n(rst_n), .start(s20), .in_valid(v20), .in_data(d20),
    .in_ready(ir20), .out_valid(ov20), .out_ready(or20),
    .acc_out(acc20), .ovf(ovf20), .busy(busy20)
  );

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s got=%0d want=%0d", name, act, exp);
    end
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, " in_ready"}, in_ready, 0);
    chk({tag, " out_valid"}, out_valid, 0);
    chk({tag, " acc_out"}, acc_out, 0);
    chk({tag, " ovf"}, ovf, 0);
    chk({tag, " busy"}, busy, 0);
  endtask

  task automatic run_tbl(input string tag);
    foreach (tbl[i]) begin
      start = tbl[i].st; in_valid = tbl[i].iv; in_data = tbl[i].d; out_ready = tbl[i].ordy;
      @(posedge clk); #1;
      chk($sformatf("%s[%0d] in_ready", tag, i), in_ready, tbl[i].e_ir);
      chk($sformatf("%s[%0d] out_valid", tag, i), out_valid, tbl[i].e_ov);
      chk($sformatf("%s[%0d] acc_out", tag, i), acc_out, tbl[i].e_acc);
      chk($sformatf("%s[%0d] ovf", tag, i), ovf, tbl[i].e_ovf);
      chk($sformatf("%s[%0d] busy", tag, i), busy, tbl[i].e_busy);
      @(negedge clk);
    end
    start = 0; in_valid = 0; out_ready = 0;
    tbl.delete();
  endtask

  task automatic run20(input logic [3:0] val, input int n, input int want_acc, input logic want_ovf);
    int ea = 0;
    logic eo = 0;
    @(negedge clk); s20 = 1;
    @(posedge clk); #1;
    chk("b20 start busy", busy20, 1);
    chk("b20 start ovf clear", ovf20, 0);
    chk("b20 start acc clear", acc20, 0);
    @(negedge clk); s20 = 0; v20 = 1; d20 = val;
    for (int k = 1; k <= n; k++) begin
      @(posedge clk); #1;
      if (ea + val > 255) eo = 1;
      ea = (ea + val) % 256;
      chk($sformatf("b20 acc k=%0d", k), acc20, ea);
      chk($sformatf("b20 ovf k=%0d", k), ovf20, eo);
      chk($sformatf("b20 out_valid k=%0d", k), ov20, k == n);
      @(negedge clk);
    end
    chk("b20 final acc", acc20, want_acc);
    chk("b20 final ovf", ovf20, want_ovf);
    v20 = 0; or20 = 1;
    @(posedge clk); #1;
    chk("b20 handoff out_valid", ov20, 0);
    chk("b20 handoff acc held", acc20, want_acc);
    @(negedge clk); or20 = 0;
  endtask

  initial begin
    // reset held: toggling inputs must have no effect
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      start = ~start; in_valid = 1; in_data = 5; out_ready = 1;
      @(negedge clk);
      chk_zero($sformatf("rst_hold%0d", i));
    end
    start = 0; in_valid = 0; out_ready = 0;
    rst_n = 1;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      chk_zero($sformatf("rst_rel%0d", i));
    end
    chk("rst dut20 acc", acc20, 0);
    chk("rst dut20 busy", busy20, 0);

    // st iv d ordy | ir ov acc ovf busy
    tbl.push_back('{1, 0, 0, 0, 1, 0, 0, 0, 1});
    tbl.push_back('{0, 1, 3, 0, 1, 0, 3, 0, 1});
    tbl.push_back('{0, 1, 5, 0, 1, 0, 8, 0, 1});
    tbl.push_back('{0, 1, 7, 0, 1, 0, 15, 0, 1});
    tbl.push_back('{0, 1, 1, 0, 0, 1, 16, 0, 1});
    tbl.push_back('{0, 0, 0, 1, 0, 0, 16, 0, 0});
    // bubbles, then 5 cycles of backpressure with junk inputs and a stray start
    tbl.push_back('{1, 0, 0, 0, 1, 0, 0, 0, 1});
    tbl.push_back('{0, 1, 0, 0, 1, 0, 0, 0, 1});
    tbl.push_back('{0, 0, 9, 0, 1, 0, 0, 0, 1});
    tbl.push_back('{0, 1, 6, 0, 1, 0, 6, 0, 1});
    tbl.push_back('{0, 0, 15, 0, 1, 0, 6, 0, 1});
    tbl.push_back('{0, 1, 0, 0, 1, 0, 6, 0, 1});
    tbl.push_back('{0, 0, 0, 0, 1, 0, 6, 0, 1});
    tbl.push_back('{0, 1, 6, 0, 0, 1, 12, 0, 1});
    tbl.push_back('{0, 1, 5, 0, 0, 1, 12, 0, 1});
    tbl.push_back('{1, 1, 5, 0, 0, 1, 12, 0, 1});
    tbl.push_back('{0, 1, 5, 0, 0, 1, 12, 0, 1});
    tbl.push_back('{0, 0, 0, 0, 0, 1, 12, 0, 1});
    tbl.push_back('{0, 0, 0, 0, 0, 1, 12, 0, 1});
    tbl.push_back('{1, 0, 0, 1, 0, 0, 12, 0, 0});
    tbl.push_back('{0, 0, 0, 0, 0, 0, 12, 0, 0});
    // start in ACC and DONE must not clear
    tbl.push_back('{1, 0, 0, 0, 1, 0, 0, 0, 1});
    tbl.push_back('{0, 1, 2, 0, 1, 0, 2, 0, 1});
    tbl.push_back('{0, 1, 2, 0, 1, 0, 4, 0, 1});
    tbl.push_back('{1, 0, 0, 0, 1, 0, 4, 0, 1});
    tbl.push_back('{1, 1, 2, 0, 1, 0, 6, 0, 1});
    tbl.push_back('{0, 1, 2, 0, 0, 1, 8, 0, 1});
    tbl.push_back('{1, 0, 0, 0, 0, 1, 8, 0, 1});
    tbl.push_back('{0, 0, 0, 1, 0, 0, 8, 0, 0});
    @(negedge clk);
    run_tbl("main");

    // mid-block asynchronous reset
    start = 1;
    @(negedge clk); start = 0; in_valid = 1; in_data = 9;
    @(negedge clk);
    @(posedge clk); #1;
    chk("mid acc before rst", acc_out, 18);
    #2 rst_n = 0;
    #1 chk_zero("mid_rst");
    @(negedge clk); in_valid = 0; rst_n = 1;
    tbl.push_back('{1, 0, 0, 0, 1, 0, 0, 0, 1});
    tbl.push_back('{0, 1, 1, 0, 1, 0, 1, 0, 1});
    tbl.push_back('{0, 1, 2, 0, 1, 0, 3, 0, 1});
    tbl.push_back('{0, 1, 3, 0, 1, 0, 6, 0, 1});
    tbl.push_back('{0, 1, 4, 0, 0, 1, 10, 0, 1});
    tbl.push_back('{0, 0, 0, 1, 0, 0, 10, 0, 0});
    run_tbl("post_rst");

    run20(4'd15, 20, 44, 1'b1);
    run20(4'd1, 20, 20, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
